// File: rtl/multi_bank_arbiter.sv
// multi_bank_arbiter: two-port round-robin arbiter in front of a 4-bank sync-read memory
// Optional conflict counter output enabled by defining CONFLICT_CNT_EN.
module multi_bank_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_a_valid,
  output logic                        o_a_ready,
  input  logic                        i_a_we,
  input  logic [ADDR_WIDTH-1:0]       i_a_addr,
  input  logic [DATA_WIDTH-1:0]       i_a_wdata,
  output logic                        o_a_rvalid,
  output logic [DATA_WIDTH-1:0]       o_a_rdata,
  input  logic                        i_b_valid,
  output logic                        o_b_ready,
  input  logic                        i_b_we,
  input  logic [ADDR_WIDTH-1:0]       i_b_addr,
  input  logic [DATA_WIDTH-1:0]       i_b_wdata,
  output logic                        o_b_rvalid,
  output logic [DATA_WIDTH-1:0]       o_b_rdata,
  output logic [3:0]                  o_bank_en,
  output logic [3:0]                  o_bank_we,
  output logic [4*(ADDR_WIDTH-2)-1:0] o_bank_addr,
  output logic [4*DATA_WIDTH-1:0]     o_bank_wdata,
  input  logic [4*DATA_WIDTH-1:0]     i_bank_rdata
`ifdef CONFLICT_CNT_EN
  ,
  output logic [15:0]                 o_conflict_cnt
`endif
);
  localparam int BW = ADDR_WIDTH - 2;
  logic [1:0] a_bank, b_bank, a_bank_p1, b_bank_p1, a_sel, b_sel;
  logic conflict, prio, a_rd_p1, b_rd_p1;
  logic [DATA_WIDTH-1:0] a_hold, b_hold;
  logic [DATA_WIDTH-1:0] rd [4];
  assign a_bank = i_a_addr[ADDR_WIDTH-1 -: 2];
  assign b_bank = i_b_addr[ADDR_WIDTH-1 -: 2];
  assign conflict = i_a_valid && i_b_valid && (a_bank == b_bank);
  assign o_a_ready = i_a_valid && (!conflict || !prio);
  assign o_b_ready = i_b_valid && (!conflict || prio);
  for (genvar g = 0; g < 4; g++) begin : g_rd
    assign rd[g] = i_bank_rdata[g*DATA_WIDTH +: DATA_WIDTH];
  end
  // Bank data is only valid in the rvalid cycle, so it is passed through then and held after.
  assign o_a_rdata = o_a_rvalid ? rd[a_sel] : a_hold;
  assign o_b_rdata = o_b_rvalid ? rd[b_sel] : b_hold;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      prio         <= 1'b0;
      o_bank_en    <= '0;
      o_bank_we    <= '0;
      o_bank_addr  <= '0;
      o_bank_wdata <= '0;
      a_rd_p1      <= 1'b0;
      b_rd_p1      <= 1'b0;
      a_bank_p1    <= '0;
      b_bank_p1    <= '0;
      o_a_rvalid   <= 1'b0;
      o_b_rvalid   <= 1'b0;
      a_sel        <= '0;
      b_sel        <= '0;
      a_hold       <= '0;
      b_hold       <= '0;
    end else begin
      if (conflict) prio <= ~prio;
      for (int k = 0; k < 4; k++) begin
        o_bank_en[k] <= (o_a_ready && a_bank == 2'(k)) || (o_b_ready && b_bank == 2'(k));
        o_bank_we[k] <= (o_a_ready && a_bank == 2'(k) && i_a_we) || (o_b_ready && b_bank == 2'(k) && i_b_we);
        if (o_a_ready && a_bank == 2'(k)) begin
          o_bank_addr[k*BW +: BW]                 <= i_a_addr[BW-1:0];
          o_bank_wdata[k*DATA_WIDTH +: DATA_WIDTH] <= i_a_wdata;
        end
        if (o_b_ready && b_bank == 2'(k)) begin
          o_bank_addr[k*BW +: BW]                 <= i_b_addr[BW-1:0];
          o_bank_wdata[k*DATA_WIDTH +: DATA_WIDTH] <= i_b_wdata;
        end
      end
      a_rd_p1    <= o_a_ready && !i_a_we;
      b_rd_p1    <= o_b_ready && !i_b_we;
      a_bank_p1  <= a_bank;
      b_bank_p1  <= b_bank;
      o_a_rvalid <= a_rd_p1;
      o_b_rvalid <= b_rd_p1;
      a_sel      <= a_bank_p1;
      b_sel      <= b_bank_p1;
      if (o_a_rvalid) a_hold <= rd[a_sel];
      if (o_b_rvalid) b_hold <= rd[b_sel];
    end
  end
`ifdef CONFLICT_CNT_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_conflict_cnt <= '0;
    else if (conflict && o_conflict_cnt != 16'hFFFF) o_conflict_cnt <= o_conflict_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_multi_bank_arbiter.sv
// tb_multi_bank_arbiter: directed checks of arbitration, issue timing and read return.
module tb_multi_bank_arbiter;
  logic        i_clk = 1'b0, i_rst = 1'b1;
  logic        a_valid = 0, a_ready, a_we = 0, a_rvalid;
  logic [5:0]  a_addr = 0;
  logic [7:0]  a_wdata = 0, a_rdata;
  logic        b_valid = 0, b_ready, b_we = 0, b_rvalid;
  logic [5:0]  b_addr = 0;
  logic [7:0]  b_wdata = 0, b_rdata;
  logic [3:0]  bank_en, bank_we;
  logic [15:0] bank_addr;
  logic [31:0] bank_wdata, bank_rdata;
  logic [7:0]  mem [64];
  logic [7:0]  exp_mem [64];
  logic [7:0]  rdreg [4];
  int pass = 0, total = 0;
`ifdef CONFLICT_CNT_EN
  logic [15:0] conflict_cnt;
`endif

  multi_bank_arbiter dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_a_valid(a_valid), .o_a_ready(a_ready), .i_a_we(a_we), .i_a_addr(a_addr),
    .i_a_wdata(a_wdata), .o_a_rvalid(a_rvalid), .o_a_rdata(a_rdata),
    .i_b_valid(b_valid), .o_b_ready(b_ready), .i_b_we(b_we), .i_b_addr(b_addr),
    .i_b_wdata(b_wdata), .o_b_rvalid(b_rvalid), .o_b_rdata(b_rdata),
    .o_bank_en(bank_en), .o_bank_we(bank_we), .o_bank_addr(bank_addr),
    .o_bank_wdata(bank_wdata), .i_bank_rdata(bank_rdata)
`ifdef CONFLICT_CNT_EN
    , .o_conflict_cnt(conflict_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  // Four sync-read banks of 16 words; word index is {bank, in-bank address}.
  always @(posedge i_clk) begin
    for (int k = 0; k < 4; k++)
      if (bank_en[k]) begin
        if (bank_we[k]) mem[{2'(k), bank_addr[k*4 +: 4]}] <= bank_wdata[k*8 +: 8];
        else rdreg[k] <= mem[{2'(k), bank_addr[k*4 +: 4]}];
      end
  end
  assign bank_rdata = {rdreg[3], rdreg[2], rdreg[1], rdreg[0]};

  task automatic test_reset;
    #1;
    total++; if (bank_en !== 4'b0 || bank_we !== 4'b0) $display("FAIL reset_en_we got %b/%b want 0000/0000", bank_en, bank_we); else pass++;
    total++; if (bank_addr !== 16'h0 || bank_wdata !== 32'h0) $display("FAIL reset_addr_wdata got %h/%h want 0/0", bank_addr, bank_wdata); else pass++;
    total++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) $display("FAIL reset_rvalid got %b%b want 00", a_rvalid, b_rvalid); else pass++;
    total++; if (a_rdata !== 8'h0 || b_rdata !== 8'h0) $display("FAIL reset_rdata got %h/%h want 00/00", a_rdata, b_rdata); else pass++;
    @(negedge i_clk); i_rst = 0;
    @(negedge i_clk); #1;
    total++; if (a_ready !== 1'b0 || b_ready !== 1'b0) $display("FAIL idle_ready got %b%b want 00", a_ready, b_ready); else pass++;
  endtask

  task automatic test_diff_banks;
    @(negedge i_clk);
    a_valid = 1; a_we = 0; a_addr = 6'h05;
    b_valid = 1; b_we = 1; b_addr = 6'h23; b_wdata = 8'hAA;
    #1;
    total++; if (a_ready !== 1'b1 || b_ready !== 1'b1) $display("FAIL diff_ready got %b%b want 11", a_ready, b_ready); else pass++;
    @(negedge i_clk);
    a_valid = 0; b_valid = 0; b_we = 0;
    exp_mem[6'h23] = 8'hAA;
    total++; if (bank_en !== 4'b0101 || bank_we !== 4'b0100) $display("FAIL diff_issue got en=%b we=%b want en=0101 we=0100", bank_en, bank_we); else pass++;
    total++; if (bank_addr[3:0] !== 4'h5 || bank_addr[11:8] !== 4'h3) $display("FAIL diff_addr got %h/%h want 5/3", bank_addr[3:0], bank_addr[11:8]); else pass++;
    total++; if (bank_wdata[23:16] !== 8'hAA) $display("FAIL diff_wdata got %h want aa", bank_wdata[23:16]); else pass++;
    @(negedge i_clk);
    total++; if (a_rvalid !== 1'b1 || a_rdata !== 8'h26) $display("FAIL diff_return got v=%b d=%h want v=1 d=26", a_rvalid, a_rdata); else pass++;
    total++; if (b_rvalid !== 1'b0) $display("FAIL write_no_rvalid got %b want 0", b_rvalid); else pass++;
    @(negedge i_clk);
    total++; if (a_rvalid !== 1'b0 || a_rdata !== 8'h26) $display("FAIL rdata_hold got v=%b d=%h want v=0 d=26", a_rvalid, a_rdata); else pass++;
    total++; if (bank_en !== 4'b0 || bank_addr[3:0] !== 4'h5) $display("FAIL idle_bank got en=%b a0=%h want 0000/5", bank_en, bank_addr[3:0]); else pass++;
  endtask

  task automatic test_conflict;
    @(negedge i_clk);
    a_valid = 1; a_addr = 6'h11; b_valid = 1; b_addr = 6'h1F;
    #1;
    total++; if (a_ready !== 1'b1 || b_ready !== 1'b0) $display("FAIL conflict_n got %b%b want 10", a_ready, b_ready); else pass++;
    @(negedge i_clk);
    a_valid = 0;
    #1;
    total++; if (a_ready !== 1'b0 || b_ready !== 1'b1) $display("FAIL conflict_n1 got %b%b want 01", a_ready, b_ready); else pass++;
    @(negedge i_clk);
    b_valid = 0;
    total++; if (a_rvalid !== 1'b1 || a_rdata !== exp_mem[6'h11] || b_rvalid !== 1'b0) $display("FAIL conflict_ret_a got v=%b%b d=%h want v=10 d=%h", a_rvalid, b_rvalid, a_rdata, exp_mem[6'h11]); else pass++;
    @(negedge i_clk);
    total++; if (b_rvalid !== 1'b1 || b_rdata !== exp_mem[6'h1F] || a_rvalid !== 1'b0) $display("FAIL conflict_ret_b got v=%b%b d=%h want v=01 d=%h", a_rvalid, b_rvalid, b_rdata, exp_mem[6'h1F]); else pass++;
  endtask

  task automatic test_reset_mid;
    @(negedge i_clk);
    a_valid = 1; a_addr = 6'h30;
    #1;
    total++; if (a_ready !== 1'b1) $display("FAIL midrst_accept got %b want 1", a_ready); else pass++;
    @(negedge i_clk);
    a_valid = 0; i_rst = 1;
    #1;
    total++; if (bank_en !== 4'b0 || a_rvalid !== 1'b0 || bank_addr !== 16'h0) $display("FAIL midrst_clear got en=%b v=%b addr=%h want 0000/0/0", bank_en, a_rvalid, bank_addr); else pass++;
    @(negedge i_clk); i_rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      total++; if (a_rvalid !== 1'b0) $display("FAIL midrst_no_rvalid cycle %0d got %b want 0", i, a_rvalid); else pass++;
    end
  endtask

  task automatic test_alternate;
    @(negedge i_clk);
    a_valid = 1; a_addr = 6'h20; b_valid = 1; b_addr = 6'h2A;
    for (int c = 0; c < 4; c++) begin
      #1;
      total++; if (a_ready !== (c % 2 == 0) || b_ready !== (c % 2 == 1)) $display("FAIL alternate cycle %0d got %b%b want %b%b", c, a_ready, b_ready, c % 2 == 0, c % 2 == 1); else pass++;
      @(negedge i_clk);
    end
    a_valid = 0; b_valid = 0;
`ifdef CONFLICT_CNT_EN
    total++; if (conflict_cnt !== 16'd4) $display("FAIL conflict_cnt got %0d want 4", conflict_cnt); else pass++;
`endif
    repeat (3) @(negedge i_clk);
  endtask

  task automatic test_stream;
    for (int i = 0; i < 66; i++) begin
      @(negedge i_clk);
      a_valid = (i < 64); a_addr = 6'(i);
      #1;
      if (i < 64) begin
        total++; if (a_ready !== 1'b1) $display("FAIL stream_ready %0d got %b want 1", i, a_ready); else pass++;
      end
      total++; if (a_rvalid !== (i >= 2)) $display("FAIL stream_rvalid %0d got %b want %b", i, a_rvalid, i >= 2); else pass++;
      if (i >= 2) begin
        total++; if (a_rdata !== exp_mem[i-2]) $display("FAIL stream_rdata %0d got %h want %h", i - 2, a_rdata, exp_mem[i-2]); else pass++;
      end
    end
    a_valid = 0;
    @(negedge i_clk);
    total++; if (a_rvalid !== 1'b0) $display("FAIL stream_end got %b want 0", a_rvalid); else pass++;
  endtask

`ifdef CONFLICT_CNT_EN
  task automatic test_saturate;
    @(negedge i_clk);
    force dut.o_conflict_cnt = 16'hFFFD;
    #1 release dut.o_conflict_cnt;
    a_valid = 1; a_addr = 6'h31; b_valid = 1; b_addr = 6'h32;
    repeat (3) @(negedge i_clk);
    a_valid = 0; b_valid = 0;
    total++; if (conflict_cnt !== 16'hFFFF) $display("FAIL cnt_saturate got %h want ffff", conflict_cnt); else pass++;
    repeat (3) @(negedge i_clk);
  endtask
`endif

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = 8'(i * 7 + 3);
      exp_mem[i] = 8'(i * 7 + 3);
    end
    for (int k = 0; k < 4; k++) rdreg[k] = 8'h0;
    repeat (2) @(negedge i_clk);
    test_reset;
    test_diff_banks;
    test_conflict;
    test_reset_mid;
    test_alternate;
    test_stream;
`ifdef CONFLICT_CNT_EN
    test_saturate;
`endif
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
